regfile_wb_writer: RTL and testbench
====================================

Name: regfile_wb_writer

Overview:
- Write-side initiator for the 4-lane, negedge-write, active-low-lane-enable register file.
- Accepts writeback requests through a valid/ready handshake and buffers them in a small FIFO. It expands full-word and unaligned-load (LWL/LWR-style) merges into lane enables and merged data.
- Drives the register file write port with one entry per cycle and forwards pending, not-yet-written lanes to two read addresses.

Parameters:
DATA_WIDTH, 32, register width; must be a multiple of 4 (lane width LW = DATA_WIDTH/4)
ADDR_WIDTH, 5, register address width
DEPTH, 2, writeback FIFO entries (>=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  writeback request present
req_ready  out  1  FIFO can accept
req_addr  in  ADDR_WIDTH  destination register
req_data  in  DATA_WIDTH  loaded/computed word
req_mode  in  2  0=FULL, 1=LWL, 2=LWR, 3=NONE
req_off  in  2  byte offset for LWL/LWR
wb_stall  in  1  hold write port idle (port borrowed elsewhere)
Rd_addr  out  ADDR_WIDTH  to regfile
Rd_in  out  DATA_WIDTH  to regfile
Rd_Byte_w_en  out  4  to regfile, active-low lane enables (4'hF = no write)
rs_addr, rt_addr  in  ADDR_WIDTH  forwarding lookup addresses
rs_fwd_mask, rt_fwd_mask  out  4  active-high lanes supplied by pending entries
rs_fwd_data, rt_fwd_data  out  DATA_WIDTH  forwarded data (valid lanes only; other lanes 0)

Behaviour:
- Reset: FIFO emptied and count=0. After the reset edge: Rd_addr=0, Rd_in=0, Rd_Byte_w_en=4'hF, req_ready=1, fwd masks 0, fwd data 0.
- Reset mid-operation discards all pending entries; nothing in flight is written afterwards.
- Handshake: transfer on posedge when req_valid && req_ready.
- req_ready = (count < DEPTH), registered-state based only. There is no same-cycle pop pass-through, so a full FIFO deasserts ready even while popping.
- Requests with req_addr==0 or mode NONE are accepted and dropped. They consume no slot and cause no write.
- Lane expansion is computed at accept and stored per entry as {addr, data, lane_mask}, where o=req_off and a lane set in lane_mask means "write this lane":
  - FULL: mask 4'b1111, data unchanged, req_off ignored.
  - LWL: mask = lanes 3 down to 3-o; data = req_data << ((3-o)*LW).
  - LWR: mask = lanes 3-o down to 0; data = req_data >> (o*LW).
- Port drive is combinational from the FIFO head register:
  - When not empty and !wb_stall: Rd_addr=head.addr, Rd_in=head.data, Rd_Byte_w_en = ~head.mask. The regfile captures on the following negedge, and the head pops on the next posedge.
  - When empty or wb_stall: Rd_Byte_w_en=4'hF, Rd_addr=0, Rd_in=0, and no pop.
- Latency: a request accepted at posedge N is on the port during cycle N+1 (empty FIFO, no stall). Throughput is 1 write per cycle.
- Simultaneous push and pop: count is unchanged and order is preserved (strict FIFO).
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Forwarding is combinational over all valid entries:
  - Per lane, the newest entry whose addr matches and whose mask covers that lane supplies the data.
  - Lookup address 0 never hits.
  - The head entry still counts during its write cycle; the regfile value is stale until the negedge.

Decomposition:
- Shared package regfile_pkg holds:
  - wb_mode_e with FULL/LWL/LWR/NONE = 0..3;
  - LANES=4;
  - IDLE_BEN=4'hF;
  - a function lane_expand(mode, off, data) returning {mask, data}.
- One natural sub-module, wb_fwd_lookup: per-lane newest-match priority search, instantiated twice (rs, rt).

Test Plan:
1. After reset, FULL addr 3 data 32'hDEADBEEF -> next cycle Rd_addr=3, Rd_in=32'hDEADBEEF, Rd_Byte_w_en=4'h0; regfile[3] reads DEADBEEF after the negedge.
2. LWL off=1 data 32'h11223344 addr 5 -> Rd_Byte_w_en=4'h3, Rd_in=32'h33440000. LWR off=2 same data -> Rd_Byte_w_en=4'hC, Rd_in=32'h00001122.
3. Hold wb_stall=1 and push 3 requests with DEPTH=2 -> req_ready drops after 2 accepts, port stays 4'hF. Release the stall -> writes issue in order on consecutive cycles, and ready rises the cycle after the first pop.
4. Stall with pending FULL addr 7 = 32'hAAAAAAAA then LWR off=2 addr 7 = 32'h12345678 (lanes 1:0 = 16'h1234); rs_addr=7 -> rs_fwd_mask=4'hF, rs_fwd_data=32'hAAAA1234.
5. Requests to addr 0 and mode NONE -> accepted, count unchanged, no port activity. rt_addr=0 -> rt_fwd_mask=0.
6. Two entries pending, rst asserted for one cycle -> after the edge the port is idle (4'hF), count=0, req_ready=1, and neither entry is ever written.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file writeback path.
// Holds the merge mode enum, lane constants and the lane expansion function.
package regfile_pkg;

  typedef enum logic [1:0] {
    WB_FULL = 2'd0,
    WB_LWL  = 2'd1,
    WB_LWR  = 2'd2,
    WB_NONE = 2'd3
  } wb_mode_e;

  localparam int LANES = 4;
  localparam logic [LANES-1:0] IDLE_BEN = 4'hF;

  // Widest supported register; callers zero-extend and truncate.
  localparam int MAX_DW = 64;

  typedef struct packed {
    logic [LANES-1:0]  mask;
    logic [MAX_DW-1:0] data;
  } lane_exp_t;

  // mask bit set = write that lane; lw is the lane width in bits
  function automatic lane_exp_t lane_expand(
    input wb_mode_e          mode,
    input logic [1:0]        off,
    input logic [MAX_DW-1:0] data,
    input int                lw
  );
    lane_exp_t r;
    r.mask = '0;
    r.data = '0;
    case (mode)
      WB_FULL: begin
        r.mask = 4'hF;
        r.data = data;
      end
      WB_LWL: begin
        r.mask = 4'hF << (2'd3 - off);
        r.data = data << ((2'd3 - off) * lw);
      end
      WB_LWR: begin
        r.mask = 4'hF >> off;
        r.data = data >> (off * lw);
      end
      default: begin
        r.mask = '0;
        r.data = '0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile_wb_writer_wb_fwd_lookup.sv
// Per-lane newest-match search over pending writeback entries.
// Ports: addr lookup, age-ordered entries (index 0 oldest), mask/data result.
module wb_fwd_lookup
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [DEPTH-1:0]                     vld,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0]     e_addr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]     e_data,
  input  logic [DEPTH-1:0][LANES-1:0]          e_mask,
  output logic [LANES-1:0]                     mask,
  output logic [DATA_WIDTH-1:0]                data
);

  localparam int LW = DATA_WIDTH / LANES;

  // Later (newer) entries overwrite earlier hits lane by lane.
  always_comb begin
    mask = '0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && addr != '0 && e_addr[i] == addr) begin
        for (int l = 0; l < LANES; l++) begin
          if (e_mask[i][l]) begin
            mask[l] = 1'b1;
            data[l*LW +: LW] = e_data[i][l*LW +: LW];
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_writer.sv
// Writeback initiator: buffers merge requests and drives the regfile write port.
// Ports: req_* handshake, wb_stall, Rd_* write port, rs/rt forwarding lookups.
module regfile_wb_writer
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_mode,
  input  logic [1:0]            req_off,
  input  logic                  wb_stall,
  output logic [ADDR_WIDTH-1:0] Rd_addr,
  output logic [DATA_WIDTH-1:0] Rd_in,
  output logic [3:0]            Rd_Byte_w_en,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [3:0]            rs_fwd_mask,
  output logic [3:0]            rt_fwd_mask,
  output logic [DATA_WIDTH-1:0] rs_fwd_data,
  output logic [DATA_WIDTH-1:0] rt_fwd_data
);

  localparam int LW = DATA_WIDTH / LANES;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;
  logic [DEPTH-1:0][LANES-1:0]      ent_mask;
  logic [PW-1:0]                    rd_ptr;
  logic [PW-1:0]                    wr_ptr;
  logic [CW-1:0]                    count;

  wb_mode_e  mode;
  lane_exp_t ex;
  logic      push;
  logic      pop;
  logic      unused_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign mode      = wb_mode_e'(req_mode);
  assign ex        = lane_expand(mode, req_off, MAX_DW'(req_data), LW);
  assign unused_ok = ^ex.data;
  assign req_ready = count < CW'(DEPTH);

  // Address 0 and NONE complete the handshake but take no slot.
  assign push = req_valid && req_ready &&
                req_addr != '0 && mode != WB_NONE;
  assign pop  = count != '0 && !wb_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ent_addr[wr_ptr] <= req_addr;
        ent_data[wr_ptr] <= ex.data[DATA_WIDTH-1:0];
        ent_mask[wr_ptr] <= ex.mask;
        wr_ptr           <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    Rd_addr      = '0;
    Rd_in        = '0;
    Rd_Byte_w_en = IDLE_BEN;
    if (pop) begin
      Rd_addr      = ent_addr[rd_ptr];
      Rd_in        = ent_data[rd_ptr];
      Rd_Byte_w_en = ~ent_mask[rd_ptr];
    end
  end

  // Re-index storage oldest-first so the lookup can prefer higher indices.
  logic [DEPTH-1:0]                 o_vld;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] o_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] o_data;
  logic [DEPTH-1:0][LANES-1:0]      o_mask;
  int                               s;
  logic [PW-1:0]                    idx;

  always_comb begin
    o_vld  = '0;
    o_addr = '0;
    o_data = '0;
    o_mask = '0;
    s      = 0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = int'(rd_ptr) + i;
      if (s >= DEPTH) s = s - DEPTH;
      idx       = PW'(s);
      o_vld[i]  = i < int'(count);
      o_addr[i] = ent_addr[idx];
      o_data[i] = ent_data[idx];
      o_mask[i] = ent_mask[idx];
    end
  end

  wb_fwd_lookup #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_rs (
    .addr(rs_addr),
    .vld(o_vld),
    .e_addr(o_addr),
    .e_data(o_data),
    .e_mask(o_mask),
    .mask(rs_fwd_mask),
    .data(rs_fwd_data)
  );

  wb_fwd_lookup #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_rt (
    .addr(rt_addr),
    .vld(o_vld),
    .e_addr(o_addr),
    .e_data(o_data),
    .e_mask(o_mask),
    .mask(rt_fwd_mask),
    .data(rt_fwd_data)
  );

endmodule

// File: tb/tb_regfile_wb_writer.sv
// Self-checking bench for regfile_wb_writer: table vectors, corner sequences,
// and random traffic against a queue-based model with a negedge regfile.
module tb_regfile_wb_writer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [1:0]    req_mode;
  logic [1:0]    req_off;
  logic          wb_stall;
  logic [AW-1:0] Rd_addr;
  logic [DW-1:0] Rd_in;
  logic [3:0]    Rd_Byte_w_en;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [3:0]    rs_fwd_mask;
  logic [3:0]    rt_fwd_mask;
  logic [DW-1:0] rs_fwd_data;
  logic [DW-1:0] rt_fwd_data;

  regfile_wb_writer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_mode(req_mode),
    .req_off(req_off),
    .wb_stall(wb_stall),
    .Rd_addr(Rd_addr),
    .Rd_in(Rd_in),
    .Rd_Byte_w_en(Rd_Byte_w_en),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .rs_fwd_mask(rs_fwd_mask),
    .rt_fwd_mask(rt_fwd_mask),
    .rs_fwd_data(rs_fwd_data),
    .rt_fwd_data(rt_fwd_data)
  );

  always #5 clk = ~clk;

  // Regfile stand-in: active-low lane enables, captured on negedge.
  logic [31:0] rf [32];
  always @(negedge clk) begin
    for (int l = 0; l < 4; l++)
      if (!Rd_Byte_w_en[l]) rf[Rd_addr][l*8 +: 8] <= Rd_in[l*8 +: 8];
  end

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_rf [32];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Lane l of the merge takes source byte lane src (if it exists).
  function automatic void expand(input logic [1:0] mode, input logic [1:0] off,
                                 input logic [31:0] d,
                                 output logic [3:0] m, output logic [31:0] o);
    int oi;
    int src;
    oi = off;
    m = 4'h0;
    o = 32'h0;
    for (int l = 0; l < 4; l++) begin
      src = -1;
      if (mode == 2'd0) src = l;
      else if (mode == 2'd1) src = l - (3 - oi);
      else if (mode == 2'd2) src = l + oi;
      if (src >= 0 && src <= 3) begin
        m[l] = 1'b1;
        o[l*8 +: 8] = d[src*8 +: 8];
      end
    end
  endfunction

  function automatic void fwd(input logic [4:0] a,
                              output logic [3:0] m, output logic [31:0] d);
    m = 4'h0;
    d = 32'h0;
    foreach (q[i])
      if (a != 5'd0 && q[i].a == a)
        for (int l = 0; l < 4; l++)
          if (q[i].m[l]) begin
            m[l] = 1'b1;
            d[l*8 +: 8] = q[i].d[l*8 +: 8];
          end
  endfunction

  // Drive inputs at posedge+1, compare everything against the model.
  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic [1:0] mo, input logic [1:0] of,
                       input logic st, input logic [4:0] ra,
                       input logic [4:0] ta);
    logic [3:0]  em;
    logic [31:0] ed;
    logic [3:0]  eb;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    req_mode  = mo;
    req_off   = of;
    wb_stall  = st;
    rs_addr   = ra;
    rt_addr   = ta;
    #1;
    chk("ready", req_ready, q.size() < D);
    if (q.size() > 0 && !st) begin
      eb = ~q[0].m;
      chk("rd_addr", Rd_addr, q[0].a);
      chk("rd_in", Rd_in, q[0].d);
      chk("ben", Rd_Byte_w_en, eb);
    end else begin
      chk("idle_addr", Rd_addr, 0);
      chk("idle_in", Rd_in, 0);
      chk("idle_ben", Rd_Byte_w_en, 4'hF);
    end
    fwd(ra, em, ed);
    chk("rs_mask", rs_fwd_mask, em);
    chk("rs_data", rs_fwd_data, ed);
    fwd(ta, em, ed);
    chk("rt_mask", rt_fwd_mask, em);
    chk("rt_data", rt_fwd_data, ed);
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'd0, st, 5'd0, 5'd0);
  endtask

  task automatic clock();
    logic popd;
    logic pushd;
    ent_t e;
    popd  = q.size() > 0 && !wb_stall;
    pushd = req_valid && q.size() < D && req_addr != 5'd0 && req_mode != 2'd3;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (popd) begin
        for (int l = 0; l < 4; l++)
          if (q[0].m[l]) exp_rf[q[0].a][l*8 +: 8] = q[0].d[l*8 +: 8];
        void'(q.pop_front());
      end
      if (pushd) begin
        e.a = req_addr;
        expand(req_mode, req_off, req_data, e.m, e.d);
        q.push_back(e);
      end
    end
    #1;
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [1:0]  mode;
    logic [1:0]  off;
    logic [31:0] d;
    logic [3:0]  ben;
    logic [31:0] din;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{5'd1, 2'd0, 2'd2, 32'h11223344, 4'h0, 32'h11223344};
    vt[1] = '{5'd5, 2'd1, 2'd1, 32'h11223344, 4'h3, 32'h33440000};
    vt[2] = '{5'd5, 2'd2, 2'd2, 32'h11223344, 4'hC, 32'h00001122};
    vt[3] = '{5'd6, 2'd1, 2'd0, 32'h11223344, 4'h7, 32'h44000000};
    vt[4] = '{5'd6, 2'd1, 2'd3, 32'h11223344, 4'h0, 32'h11223344};
    vt[5] = '{5'd8, 2'd2, 2'd0, 32'h11223344, 4'h0, 32'h11223344};
    vt[6] = '{5'd8, 2'd2, 2'd3, 32'h11223344, 4'hE, 32'h00000011};
    vt[7] = '{5'd2, 2'd2, 2'd1, 32'hA1B2C3D4, 4'h8, 32'h00A1B2C3};

    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'h0;
      exp_rf[i] = 32'h0;
    end
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_mode = '0;
    req_off = '0;
    wb_stall = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
    clock();
    clock();
    rst = 1'b0;

    idle(1'b0);
    chk("rst_ready", req_ready, 1);
    chk("rst_ben", Rd_Byte_w_en, 4'hF);
    chk("rst_addr", Rd_addr, 0);
    chk("rst_in", Rd_in, 0);
    chk("rst_fwd", {rs_fwd_mask, rt_fwd_mask}, 0);
    chk("rst_fwd_d", {rs_fwd_data, rt_fwd_data}, 0);
    clock();

    // full write, seen by the regfile after the negedge
    drive(1'b1, 5'd3, 32'hDEADBEEF, 2'd0, 2'd0, 1'b0, 5'd0, 5'd0);
    clock();
    idle(1'b0);
    chk("t1_addr", Rd_addr, 3);
    chk("t1_in", Rd_in, 32'hDEADBEEF);
    chk("t1_ben", Rd_Byte_w_en, 4'h0);
    @(negedge clk);
    #1;
    chk("t1_rf3", rf[3], 32'hDEADBEEF);
    clock();

    foreach (vt[i]) begin
      drive(1'b1, vt[i].a, vt[i].d, vt[i].mode, vt[i].off, 1'b0, 5'd0, 5'd0);
      clock();
      idle(1'b0);
      chk($sformatf("vec%0d_ben", i), Rd_Byte_w_en, vt[i].ben);
      chk($sformatf("vec%0d_in", i), Rd_in, vt[i].din);
      clock();
    end

    // stalled fill, then in-order drain
    drive(1'b1, 5'd11, 32'h11111111, 2'd0, 2'd0, 1'b1, 5'd0, 5'd0);
    clock();
    drive(1'b1, 5'd12, 32'h22222222, 2'd0, 2'd0, 1'b1, 5'd0, 5'd0);
    clock();
    drive(1'b1, 5'd13, 32'h33333333, 2'd0, 2'd0, 1'b1, 5'd0, 5'd0);
    chk("t3_full", req_ready, 0);
    chk("t3_stall_ben", Rd_Byte_w_en, 4'hF);
    clock();
    drive(1'b1, 5'd13, 32'h33333333, 2'd0, 2'd0, 1'b0, 5'd0, 5'd0);
    chk("t3_pop_ready", req_ready, 0);
    chk("t3_w1", Rd_addr, 11);
    clock();
    drive(1'b1, 5'd13, 32'h33333333, 2'd0, 2'd0, 1'b0, 5'd0, 5'd0);
    chk("t3_ready_up", req_ready, 1);
    chk("t3_w2", Rd_addr, 12);
    clock();
    idle(1'b0);
    chk("t3_w3", Rd_addr, 13);
    chk("t3_w3_in", Rd_in, 32'h33333333);
    clock();

    // forwarding merge across two pending entries
    drive(1'b1, 5'd7, 32'hAAAAAAAA, 2'd0, 2'd0, 1'b1, 5'd0, 5'd0);
    clock();
    drive(1'b1, 5'd7, 32'h12345678, 2'd2, 2'd2, 1'b1, 5'd0, 5'd0);
    clock();
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'd0, 1'b1, 5'd7, 5'd7);
    chk("t4_rs_mask", rs_fwd_mask, 4'hF);
    chk("t4_rs_data", rs_fwd_data, 32'hAAAA1234);
    clock();
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd7, 5'd0);
    chk("t4_head_fwd", rs_fwd_data, 32'hAAAA1234);
    clock();
    idle(1'b0);
    clock();

    // dropped requests
    drive(1'b1, 5'd0, 32'hCAFEF00D, 2'd0, 2'd0, 1'b0, 5'd0, 5'd0);
    chk("t5_ready0", req_ready, 1);
    clock();
    drive(1'b1, 5'd4, 32'hCAFEF00D, 2'd3, 2'd0, 1'b0, 5'd0, 5'd0);
    chk("t5_ben0", Rd_Byte_w_en, 4'hF);
    clock();
    drive(1'b0, 5'd0, 32'h0, 2'd0, 2'd0, 1'b0, 5'd4, 5'd0);
    chk("t5_ben1", Rd_Byte_w_en, 4'hF);
    chk("t5_rt0", rt_fwd_mask, 0);
    chk("t5_rs4", rs_fwd_mask, 0);
    clock();

    // reset discards pending entries
    drive(1'b1, 5'd9, 32'h99999999, 2'd0, 2'd0, 1'b1, 5'd0, 5'd0);
    clock();
    drive(1'b1, 5'd10, 32'h10101010, 2'd0, 2'd0, 1'b1, 5'd0, 5'd0);
    clock();
    rst = 1'b1;
    idle(1'b1);
    clock();
    rst = 1'b0;
    idle(1'b0);
    chk("t6_ben", Rd_Byte_w_en, 4'hF);
    chk("t6_ready", req_ready, 1);
    clock();
    repeat (3) begin
      idle(1'b0);
      clock();
    end
    chk("t6_rf9", rf[9], 0);
    chk("t6_rf10", rf[10], 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic        v;
      logic [4:0]  a;
      logic        st;
      v  = $urandom_range(0, 9) < 7;
      a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(0, 7));
      st = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 99) == 0;
      if (rst) st = 1'b1;
      drive(v, a, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            st, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      clock();
      rst = 1'b0;
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      idle(1'b0);
      clock();
    end
    idle(1'b0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("rf%0d", i), rf[i], exp_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
